// File: rtl/mem_xfer_ctrl.sv
// Buffer load/save sequencer: moves a programmed number of words between external
// memory and the on-chip buffer, one request/acknowledge transaction per word.
module mem_xfer_ctrl #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned EXT_AW = 32,
   parameter int unsigned BUF_AW = 16,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              save_start,
   input  logic              abrupt_end,
   input  logic [EXT_AW-1:0] load_ext_addr,
   input  logic [CNT_W-1:0]  load_words,
   input  logic [BUF_AW-1:0] load_buf_addr,
   input  logic [EXT_AW-1:0] save_ext_addr,
   input  logic [CNT_W-1:0]  save_words,
   input  logic [BUF_AW-1:0] save_buf_addr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [EXT_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              buf_wr_en,
   output logic              buf_rd_en,
   output logic [BUF_AW-1:0] buf_addr,
   output logic [DATA_W-1:0] buf_wdata,
   input  logic [DATA_W-1:0] buf_rdata,
   output logic              busy,
   output logic              buffer_loaded,
   output logic              buffer_saved,
   output logic [15:0]       status
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LD_REQ = 3'd1,
      LD_WR  = 3'd2,
      SV_RD  = 3'd3,
      SV_CAP = 3'd4,
      SV_REQ = 3'd5,
      DONE   = 3'd6
   } state_e;

   state_e            state_q, state_d;
   logic [EXT_AW-1:0] curExt_q, curExt_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [BUF_AW-1:0] curBuf_q, curBuf_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              op_q, op_d;
   logic              aborted_q, aborted_d;
   logic              zeroLen_q, zeroLen_d;
   logic              loaded_q, loaded_d;
   logic              saved_q, saved_d;
   logic              advance;
   logic              lastWord;

   // State and datapath registers; everything clears on the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         curExt_q    <= '0;
         remaining_q <= '0;
         curBuf_q    <= '0;
         data_q      <= '0;
         op_q        <= 1'b0;
         aborted_q   <= 1'b0;
         zeroLen_q   <= 1'b0;
         loaded_q    <= 1'b0;
         saved_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         curExt_q    <= curExt_d;
         remaining_q <= remaining_d;
         curBuf_q    <= curBuf_d;
         data_q      <= data_d;
         op_q        <= op_d;
         aborted_q   <= aborted_d;
         zeroLen_q   <= zeroLen_d;
         loaded_q    <= loaded_d;
         saved_q     <= saved_d;
      end
   end

   assign lastWord = (remaining_q == CNT_W'(1));

   // Next-state and output decode; outputs depend only on the current state so
   // an abort withdraws the request and strobes on the following cycle.
   always_comb begin
      state_d     = state_q;
      curExt_d    = curExt_q;
      remaining_d = remaining_q;
      curBuf_d    = curBuf_q;
      data_d      = data_q;
      op_d        = op_q;
      aborted_d   = aborted_q;
      zeroLen_d   = zeroLen_q;
      loaded_d    = loaded_q;
      saved_d     = saved_q;
      advance     = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      buf_wr_en   = 1'b0;
      buf_rd_en   = 1'b0;
      buf_addr    = '0;
      buf_wdata   = '0;

      case (state_q)
         IDLE: begin
            if (load_start) begin
               curExt_d    = load_ext_addr;
               remaining_d = load_words;
               curBuf_d    = load_buf_addr;
               loaded_d    = 1'b0;
               aborted_d   = 1'b0;
               op_d        = 1'b0;
               zeroLen_d   = (load_words == '0);
               state_d     = (load_words == '0) ? DONE : LD_REQ;
            end else if (save_start) begin
               curExt_d    = save_ext_addr;
               remaining_d = save_words;
               curBuf_d    = save_buf_addr;
               saved_d     = 1'b0;
               aborted_d   = 1'b0;
               op_d        = 1'b1;
               zeroLen_d   = (save_words == '0);
               state_d     = (save_words == '0) ? DONE : SV_RD;
            end
         end

         LD_REQ: begin
            mem_req  = 1'b1;
            mem_addr = curExt_q;
            if (mem_ack) begin
               data_d  = mem_rdata;
               state_d = LD_WR;
            end
         end

         LD_WR: begin
            buf_wr_en = 1'b1;
            buf_addr  = curBuf_q;
            buf_wdata = data_q;
            advance   = 1'b1;
            state_d   = lastWord ? DONE : LD_REQ;
         end

         SV_RD: begin
            buf_rd_en = 1'b1;
            buf_addr  = curBuf_q;
            state_d   = SV_CAP;
         end

         SV_CAP: begin
            data_d  = buf_rdata;
            state_d = SV_REQ;
         end

         SV_REQ: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = curExt_q;
            mem_wdata = data_q;
            if (mem_ack) begin
               advance = 1'b1;
               state_d = lastWord ? DONE : SV_RD;
            end
         end

         DONE: begin
            if (op_q) saved_d = 1'b1;
            else      loaded_d = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // Abort beats any acknowledge or completion seen in the same cycle.
      if (abrupt_end && (state_q != IDLE)) begin
         state_d   = IDLE;
         aborted_d = 1'b1;
         advance   = 1'b0;
         data_d    = data_q;
         loaded_d  = loaded_q;
         saved_d   = saved_q;
      end

      if (advance) begin
         curExt_d    = curExt_q + EXT_AW'(1);
         curBuf_d    = curBuf_q + BUF_AW'(1);
         remaining_d = remaining_q - CNT_W'(1);
      end
   end

   assign busy          = (state_q != IDLE);
   assign buffer_loaded = loaded_q;
   assign buffer_saved  = saved_q;
   assign status        = {busy, aborted_q, op_q, zeroLen_q, state_q, 9'h000};

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Directed bench for mem_xfer_ctrl with a memory/buffer responder and a scoreboard
// of expected buffer writes and memory transactions.
module tb_mem_xfer_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0;
   logic        save_start = 1'b0;
   logic        abrupt_end = 1'b0;
   logic [31:0] load_ext_addr = '0;
   logic [31:0] load_words = '0;
   logic [15:0] load_buf_addr = '0;
   logic [31:0] save_ext_addr = '0;
   logic [31:0] save_words = '0;
   logic [15:0] save_buf_addr = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        buf_wr_en;
   logic        buf_rd_en;
   logic [15:0] buf_addr;
   logic [15:0] buf_wdata;
   logic [15:0] buf_rdata = '0;
   logic        busy;
   logic        buffer_loaded;
   logic        buffer_saved;
   logic [15:0] status;

   mem_xfer_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .save_start(save_start), .abrupt_end(abrupt_end),
      .load_ext_addr(load_ext_addr), .load_words(load_words), .load_buf_addr(load_buf_addr),
      .save_ext_addr(save_ext_addr), .save_words(save_words), .save_buf_addr(save_buf_addr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .buf_wr_en(buf_wr_en), .buf_rd_en(buf_rd_en), .buf_addr(buf_addr),
      .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
      .busy(busy), .buffer_loaded(buffer_loaded), .buffer_saved(buffer_saved),
      .status(status)
   );

   always #5 clk = ~clk;

   typedef struct { logic we; logic [31:0] addr; logic [15:0] data; } memTxn_t;
   typedef struct { logic [15:0] addr; logic [15:0] data; } bufTxn_t;

   memTxn_t memQ[$];
   bufTxn_t bufQ[$];
   int total = 0;
   int bad = 0;
   int ackDelay = 0;
   int waitCnt = 0;
   int bufWrCount = 0;
   int cycle = 0;
   int lastWrCycle = -1;
   bit spacingCheck = 1'b0;

   function automatic logic [15:0] memWord(input logic [31:0] a);
      return 16'hA000 | {4'h0, a[11:0]};
   endfunction

   function automatic logic [15:0] bufWord(input logic [15:0] a);
      return 16'hB000 | {4'h0, a[11:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic ld, input logic sv, input logic ab);
      load_start = ld;
      save_start = sv;
      abrupt_end = ab;
      @(negedge clk);
      load_start = 1'b0;
      save_start = 1'b0;
      abrupt_end = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input int maxCycles);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < maxCycles);
      checkOutput(tag, 32'(busy), 0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_memReq"}, 32'(mem_req), 0);
      checkOutput({tag, "_memAddr"}, mem_addr, 0);
      checkOutput({tag, "_bufStrobes"}, 32'({buf_wr_en, buf_rd_en, mem_we}), 0);
      checkOutput({tag, "_busy"}, 32'(busy), 0);
      checkOutput({tag, "_flags"}, 32'({buffer_loaded, buffer_saved}), 0);
      checkOutput({tag, "_status"}, 32'(status), 0);
   endtask

   // Memory/buffer responder and scoreboard checker, evaluated on every falling edge.
   initial begin
      bufTxn_t eb;
      memTxn_t em;
      logic        prevPending;
      logic [31:0] prevAddr;
      logic [15:0] prevWdata;
      prevPending = 1'b0;
      prevAddr = '0;
      prevWdata = '0;
      forever begin
         @(negedge clk);
         cycle++;
         if (!rst_n) begin
            mem_ack = 1'b0;
            waitCnt = 0;
            prevPending = 1'b0;
         end else begin
            if (buf_wr_en) begin
               if (bufQ.size() == 0) checkOutput("unexpectedBufWrite", 32'(buf_addr), 32'hFFFF_FFFF);
               else begin
                  eb = bufQ.pop_front();
                  checkOutput("bufWrAddr", 32'(buf_addr), 32'(eb.addr));
                  checkOutput("bufWrData", 32'(buf_wdata), 32'(eb.data));
               end
               if (spacingCheck && lastWrCycle >= 0) checkOutput("loadSpacing", cycle - lastWrCycle, 2);
               lastWrCycle = cycle;
               bufWrCount++;
            end
            if (buf_rd_en) buf_rdata = bufWord(buf_addr);
            if (mem_req && prevPending) begin
               checkOutput("reqAddrStable", mem_addr, prevAddr);
               if (mem_we) checkOutput("reqWdataStable", 32'(mem_wdata), 32'(prevWdata));
            end
            if (mem_req && !mem_ack) begin
               if (waitCnt >= ackDelay) begin
                  mem_ack = 1'b1;
                  mem_rdata = memWord(mem_addr);
               end else waitCnt++;
            end else begin
               mem_ack = 1'b0;
               waitCnt = 0;
            end
            if (mem_req && mem_ack) begin
               if (memQ.size() == 0) checkOutput("unexpectedMemTxn", mem_addr, 32'hDEAD_BEEF);
               else begin
                  em = memQ.pop_front();
                  checkOutput("memWe", 32'(mem_we), 32'(em.we));
                  checkOutput("memAddr", mem_addr, em.addr);
                  if (em.we) checkOutput("memWdata", 32'(mem_wdata), 32'(em.data));
               end
            end
            prevPending = mem_req && !mem_ack;
            prevAddr = mem_addr;
            prevWdata = mem_wdata;
         end
      end
   end

   // Directed sequence of transfers.
   initial begin
      int n;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Four-word load, zero-wait acknowledge, two cycles per word.
      for (int i = 0; i < 4; i++) begin
         bufQ.push_back('{16'(16'h0010 + i), 16'(16'hA000 + i)});
         memQ.push_back('{1'b0, 32'h0000_1000 + i, 16'h0});
      end
      load_ext_addr = 32'h0000_1000; load_words = 4; load_buf_addr = 16'h0010;
      ackDelay = 0; spacingCheck = 1'b1; lastWrCycle = -1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t1_statusRun", 32'(status), 'h8200);
      waitIdle("t1_idle", 40);
      spacingCheck = 1'b0;
      checkOutput("t1_loaded", 32'(buffer_loaded), 1);
      checkOutput("t1_status", 32'(status), 'h0000);
      checkOutput("t1_bufQ", bufQ.size(), 0);
      checkOutput("t1_memQ", memQ.size(), 0);

      // Three-word save across the external address wrap, delayed acknowledge.
      memQ.push_back('{1'b1, 32'hFFFF_FFFF, 16'hB020});
      memQ.push_back('{1'b1, 32'h0000_0000, 16'hB021});
      memQ.push_back('{1'b1, 32'h0000_0001, 16'hB022});
      save_ext_addr = 32'hFFFF_FFFF; save_words = 3; save_buf_addr = 16'h0020;
      ackDelay = 2;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("t2_statusRun", 32'(status), 'hA600);
      waitIdle("t2_idle", 80);
      checkOutput("t2_saved", 32'(buffer_saved), 1);
      checkOutput("t2_loadedSticky", 32'(buffer_loaded), 1);
      checkOutput("t2_status", 32'(status), 'h2000);
      checkOutput("t2_memQ", memQ.size(), 0);

      // Simultaneous starts: load wins; a later save pulse while busy is ignored.
      bufQ.push_back('{16'hFFFF, 16'hA000});
      bufQ.push_back('{16'h0000, 16'hA001});
      memQ.push_back('{1'b0, 32'h0000_2000, 16'h0});
      memQ.push_back('{1'b0, 32'h0000_2001, 16'h0});
      load_ext_addr = 32'h0000_2000; load_words = 2; load_buf_addr = 16'hFFFF;
      save_ext_addr = 32'h0000_5000; save_words = 5; save_buf_addr = 16'h0050;
      ackDelay = 0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("t3_statusRun", 32'(status), 'h8200);
      checkOutput("t3_flags", 32'({buffer_loaded, buffer_saved}), 'b01);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitIdle("t3_idle", 40);
      checkOutput("t3_flagsDone", 32'({buffer_loaded, buffer_saved}), 'b11);
      checkOutput("t3_status", 32'(status), 'h0000);
      checkOutput("t3_queues", bufQ.size() + memQ.size(), 0);

      // Abort during the third request of an eight-word load.
      for (int i = 0; i < 2; i++) begin
         bufQ.push_back('{16'(16'h0080 + i), 16'(16'hA000 + i)});
         memQ.push_back('{1'b0, 32'h0000_4000 + i, 16'h0});
      end
      load_ext_addr = 32'h0000_4000; load_words = 8; load_buf_addr = 16'h0080;
      ackDelay = 3; bufWrCount = 0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      n = 0;
      while (!(bufWrCount == 2 && mem_req) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t4_reachedReq3", 32'(n < 100), 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("t4_busy", 32'(busy), 0);
      checkOutput("t4_memReq", 32'(mem_req), 0);
      checkOutput("t4_status", 32'(status), 'h4000);
      checkOutput("t4_loaded", 32'(buffer_loaded), 0);
      repeat (3) @(negedge clk);
      checkOutput("t4_bufWrites", bufWrCount, 2);
      checkOutput("t4_queues", bufQ.size() + memQ.size(), 0);

      // Zero-length load: straight to DONE, no memory request.
      load_ext_addr = 32'h0000_6000; load_words = 0; load_buf_addr = 16'h0060;
      ackDelay = 0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t5_statusDone", 32'(status), 'h9C00);
      checkOutput("t5_memReq", 32'(mem_req), 0);
      @(negedge clk);
      checkOutput("t5_busy", 32'(busy), 0);
      checkOutput("t5_loaded", 32'(buffer_loaded), 1);
      checkOutput("t5_status", 32'(status), 'h1000);

      // Reset while a save request is outstanding, then a fresh load.
      save_ext_addr = 32'h0000_7000; save_words = 4; save_buf_addr = 16'h0070;
      ackDelay = 5;
      applyStimulus(1'b0, 1'b1, 1'b0);
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t6_reqSeen", 32'(mem_req), 1);
      rst_n = 1'b0;
      #1;
      checkAllZero("t6_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bufQ.push_back('{16'h0040, 16'hA000});
      memQ.push_back('{1'b0, 32'h0000_3000, 16'h0});
      load_ext_addr = 32'h0000_3000; load_words = 1; load_buf_addr = 16'h0040;
      ackDelay = 0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t6_busyAfterStart", 32'(busy), 1);
      waitIdle("t6_idle", 40);
      checkOutput("t6_loaded", 32'(buffer_loaded), 1);
      checkOutput("t6_queues", bufQ.size() + memQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
